// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the up/down modulo counter
package counter_pkg;
  typedef enum logic [1:0] {MODE_WRAP, MODE_SAT, MODE_ONESHOT} cnt_mode_e;
  typedef enum logic {ST_RUN, ST_HALT} cnt_state_e;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/counter_step.sv
// counter_step: next-count and bound detection for one enabled step
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD = 256
) (
  input  logic [WIDTH-1:0] count,
  input  logic             m,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             at_bound,
  output logic             is_up
);
  localparam logic [WIDTH:0] MAXV = MOD[WIDTH:0] - 1'b1;
  logic [WIDTH:0] wide;
  assign wide = {1'b0, count};
  assign is_up = m == DIR_UP;
  assign at_bound = is_up ? wide == MAXV : wide == '0;
  assign next_count = !at_bound ? (is_up ? count + 1'b1 : count - 1'b1) :
                      mode != MODE_WRAP ? count :
                      is_up ? '0 : MAXV[WIDTH-1:0];
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable up/down modulo counter with wrap/saturate/one-shot end policies
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode_sel,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             halted,
  output logic             match
);
  localparam logic [WIDTH:0] MODW = MOD[WIDTH:0];
  localparam logic [WIDTH:0] MAXV = MODW - 1'b1;
  cnt_state_e state;
  cnt_mode_e mode;
  logic [WIDTH-1:0] next_count, din_clamped;
  logic at_bound, is_up, go, bound_hit;
  assign mode = mode_sel == 2'b11 ? MODE_WRAP : cnt_mode_e'(mode_sel);
  assign go = en && !load && state == ST_RUN;
  assign bound_hit = go && at_bound;
  assign din_clamped = {1'b0, din} >= MODW ? MAXV[WIDTH-1:0] : din;
  assign match = count == cmp_val;
  assign halted = state == ST_HALT;
  counter_step #(.WIDTH(WIDTH), .MOD(MOD)) u_step (
    .count(count),
    .m(m),
    .mode(mode),
    .next_count(next_count),
    .at_bound(at_bound),
    .is_up(is_up)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      state <= ST_RUN;
    end else begin
      tc <= bound_hit;
      ovf <= (ovf && !clr_flags) || (bound_hit && is_up);
      unf <= (unf && !clr_flags) || (bound_hit && !is_up);
      if (load) begin
        count <= din_clamped;
        state <= ST_RUN;
      end else if (go) begin
        count <= next_count;
        if (at_bound && mode == MODE_ONESHOT) state <= ST_HALT;
      end
    end
  end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed and random checks of two counter instances against an arithmetic model
module tb_updown_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, m, load, clr_flags;
  logic [7:0] din, cmp_val;
  logic [1:0] mode_sel;
  logic [7:0] count_a, count_b;
  logic tc_a, ovf_a, unf_a, halted_a, match_a;
  logic tc_b, ovf_b, unf_b, halted_b, match_b;
  int checks = 0;
  int failures = 0;
  int mc[2], mtc[2], movf[2], munf[2], mhalt[2];
  int modv[2] = '{256, 10};
  updown_mod_counter #(.WIDTH(8), .MOD(256)) dut_a (
    .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .din(din),
    .mode_sel(mode_sel), .cmp_val(cmp_val), .clr_flags(clr_flags),
    .count(count_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a), .halted(halted_a), .match(match_a)
  );
  updown_mod_counter #(.WIDTH(8), .MOD(10)) dut_b (
    .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .din(din),
    .mode_sel(mode_sel), .cmp_val(cmp_val), .clr_flags(clr_flags),
    .count(count_b), .tc(tc_b), .ovf(ovf_b), .unf(unf_b), .halted(halted_b), .match(match_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int eff;
      eff = mode_sel == 2'd3 ? 0 : int'(mode_sel);
      if (rst) begin
        mc[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0; mhalt[k] = 0;
      end else begin
        if (clr_flags) begin
          movf[k] = 0; munf[k] = 0;
        end
        mtc[k] = 0;
        if (load) begin
          mc[k] = int'(din) > modv[k] - 1 ? modv[k] - 1 : int'(din);
          mhalt[k] = 0;
        end else if (en && mhalt[k] == 0) begin
          if (!m && mc[k] == modv[k] - 1) begin
            mtc[k] = 1; movf[k] = 1;
            if (eff == 0) mc[k] = 0;
            else if (eff == 2) mhalt[k] = 1;
          end else if (m && mc[k] == 0) begin
            mtc[k] = 1; munf[k] = 1;
            if (eff == 0) mc[k] = modv[k] - 1;
            else if (eff == 2) mhalt[k] = 1;
          end else begin
            mc[k] = m ? mc[k] - 1 : mc[k] + 1;
          end
        end
      end
    end
  endtask
  task automatic compare_all();
    check("count_a", count_a, mc[0]);
    check("tc_a", tc_a, mtc[0]);
    check("ovf_a", ovf_a, movf[0]);
    check("unf_a", unf_a, munf[0]);
    check("halted_a", halted_a, mhalt[0]);
    check("match_a", match_a, mc[0] == int'(cmp_val));
    check("count_b", count_b, mc[1]);
    check("tc_b", tc_b, mtc[1]);
    check("ovf_b", ovf_b, movf[1]);
    check("unf_b", unf_b, munf[1]);
    check("halted_b", halted_b, mhalt[1]);
    check("match_b", match_b, mc[1] == int'(cmp_val));
  endtask
  task automatic cyc(input logic r, input logic l, input logic [7:0] d, input logic e,
                     input logic dir, input logic [1:0] ms, input logic c, input logic [7:0] cv);
    rst = r; load = l; din = d; en = e; m = dir; mode_sel = ms; clr_flags = c; cmp_val = cv;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask
  initial begin
    rst = 1'b1; load = 1'b0; din = '0; en = 1'b0; m = 1'b0; mode_sel = 2'd0; clr_flags = 1'b0; cmp_val = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_count", count_a, 0);
    check("rst_halted", halted_a, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0, 0);
    check("t1_count", count_a, 3);
    check("t1_tc", tc_a, 0);
    cyc(0, 1, 100, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_hold", count_a, 100);
    cyc(0, 1, 200, 0, 0, 0, 0, 202);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 0, 202);
    check("t3_count", count_a, 202);
    check("t3_match", match_a, 1);
    cyc(0, 1, 5, 0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 1, 0, 0, 0);
    check("t4_zero", count_a, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    check("t4_wrap", count_a, 255);
    check("t4_tc", tc_a, 1);
    check("t4_unf", unf_a, 1);
    cyc(0, 1, 255, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    check("t5_wrap", count_a, 0);
    check("t5_ovf", ovf_a, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    check("t5_tc_off", tc_a, 0);
    check("t5_ovf_sticky", ovf_a, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_clr", ovf_a, 0);
    cyc(0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, 1, 0, 0);
      check("t6_sat_count", count_a, 0);
      check("t6_sat_tc", tc_a, 1);
    end
    cyc(0, 1, 254, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 1, 0, 2, 0, 0);
    check("t7_255", count_a, 255);
    cyc(0, 0, 0, 1, 0, 2, 0, 0);
    check("t7_halt", halted_a, 1);
    check("t7_tc", tc_a, 1);
    cyc(0, 0, 0, 1, 0, 2, 0, 0);
    check("t7_tc_once", tc_a, 0);
    check("t7_hold", count_a, 255);
    cyc(0, 1, 10, 1, 0, 2, 0, 0);
    check("t7_reload", count_a, 10);
    check("t7_run", halted_a, 0);
    cyc(0, 1, 5, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    check("t8_rst", count_a, 0);
    check("t8_flags", {ovf_a, unf_a, halted_a}, 0);
    cyc(0, 1, 7, 1, 0, 0, 0, 0);
    check("t8_load_pri", count_a, 7);
    cyc(0, 1, 12, 0, 0, 0, 0, 0);
    check("t9_clamp", count_b, 9);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    check("t9_wrap", count_b, 0);
    check("t9_tc", tc_b, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0 ? ~m : m,
          $urandom_range(0, 15) == 0 ? 2'($urandom) : mode_sel,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) == 0 ? count_a : 8'($urandom_range(0, 12)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
